// File: rtl/spi_controller.sv
// SPI mode-0 bus controller: shifts words out on MOSI and in from MISO, MSB first,
// with SCLK derived from clk by a CLK_DIV half-period divider and optional CS-held streaming.
module spi_controller #(
  parameter int DATA_BITS = 8,
  parameter int CLK_DIV   = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [DATA_BITS-1:0] i_tx_data,
  input  logic                 i_tx_valid,
  input  logic                 i_tx_last,
  output logic                 o_tx_ready,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_valid,
  output logic                 o_sclk,
  output logic                 o_cs,
  output logic                 o_mosi,
  input  logic                 i_miso
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [DIV_W-1:0] DIV_END = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_END = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_LEAD, S_HIGH, S_LOW, S_TRAIL} state_t;

  state_t                 r_state;
  logic [DIV_W-1:0]       r_div_cnt;
  logic [BIT_W-1:0]       r_bit_cnt;
  logic [DATA_BITS-1:0]   r_tx_shift;
  logic [DATA_BITS-2:0]   r_rx_shift;
  logic                   r_last;
  logic                   r_sclk;
  logic                   r_cs;
  logic                   r_mosi;
  logic [DATA_BITS-1:0]   r_rx_data;
  logic                   r_rx_valid;

  logic                   w_div_end;
  logic                   w_last_bit;
  logic                   w_tx_ready;
  logic                   w_accept;
  logic [DATA_BITS-1:0]   w_rx_word;

  assign w_div_end  = (r_div_cnt == DIV_END);
  assign w_last_bit = (r_state == S_HIGH) && w_div_end && (r_bit_cnt == BIT_END);
  // The mid-frame ready pulse lets the next word chain on without releasing CS.
  assign w_tx_ready = (r_state == S_IDLE) || (w_last_bit && !r_last);
  assign w_accept   = i_tx_valid && w_tx_ready;
  assign w_rx_word  = {r_rx_shift, i_miso};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_div_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_last     <= 1'b0;
      r_sclk     <= 1'b0;
      r_cs       <= 1'b1;
      r_mosi     <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_tx_shift <= i_tx_data;
            r_mosi     <= i_tx_data[DATA_BITS-1];
            r_last     <= i_tx_last;
            r_bit_cnt  <= '0;
            r_div_cnt  <= '0;
            r_cs       <= 1'b0;
            r_state    <= S_LEAD;
          end
        end
        S_LEAD: begin
          if (w_div_end) begin
            r_div_cnt <= '0;
            r_sclk    <= 1'b1;
            r_state   <= S_HIGH;
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end
        S_HIGH: begin
          if (w_div_end) begin
            r_div_cnt  <= '0;
            r_sclk     <= 1'b0;
            r_rx_shift <= w_rx_word[DATA_BITS-2:0];
            r_bit_cnt  <= r_bit_cnt + 1'b1;
            if (!w_last_bit) begin
              r_tx_shift <= r_tx_shift << 1;
              r_mosi     <= r_tx_shift[DATA_BITS-2];
              r_state    <= S_LOW;
            end else begin
              r_rx_data  <= w_rx_word;
              r_rx_valid <= 1'b1;
              if (w_accept) begin
                r_tx_shift <= i_tx_data;
                r_mosi     <= i_tx_data[DATA_BITS-1];
                r_last     <= i_tx_last;
                r_bit_cnt  <= '0;
                r_state    <= S_LOW;
              end else begin
                r_state <= S_TRAIL;
              end
            end
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end
        S_LOW: begin
          if (w_div_end) begin
            r_div_cnt <= '0;
            r_sclk    <= 1'b1;
            r_state   <= S_HIGH;
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end
        S_TRAIL: begin
          if (w_div_end) begin
            r_div_cnt <= '0;
            r_cs      <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_tx_ready = w_tx_ready;
  assign o_rx_data  = r_rx_data;
  assign o_rx_valid = r_rx_valid;
  assign o_sclk     = r_sclk;
  assign o_cs       = r_cs;
  assign o_mosi     = r_mosi;

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller: loopback, SPI device model and constant MISO,
// with a receive scoreboard and a negedge bus monitor.
module tb_spi_controller;
  localparam int N = 8;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] tx_data = '0;
  logic         tx_valid = 1'b0;
  logic         tx_last = 1'b0;
  logic         tx_ready;
  logic [N-1:0] rx_data;
  logic         rx_valid;
  logic         sclk;
  logic         cs;
  logic         mosi;
  logic         miso;

  int miso_mode = 0;  // 0 loopback, 1 tied high, 2 tied low, 3 device model
  logic [7:0] d_tx = '0;
  assign miso = (miso_mode == 0) ? mosi :
                (miso_mode == 1) ? 1'b1 :
                (miso_mode == 2) ? 1'b0 : d_tx[7];

  spi_controller #(.DATA_BITS(N), .CLK_DIV(D)) dut (
    .i_clk(clk), .i_reset(reset), .i_tx_data(tx_data), .i_tx_valid(tx_valid),
    .i_tx_last(tx_last), .o_tx_ready(tx_ready), .o_rx_data(rx_data),
    .o_rx_valid(rx_valid), .o_sclk(sclk), .o_cs(cs), .o_mosi(mosi), .i_miso(miso)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int t0 = 0;
  logic [N-1:0] sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Bus monitor: edge counts and cycle stamps relative to the latest accept edge.
  int rise_cnt, first_rise, last_rise, hi_len, width_err, mosi_err;
  int cs_fall_cnt, cs_fall_cyc, cs_rise_cyc, rv_cnt, rv_cyc;
  logic ready_at_rise;
  logic m_sclk = 1'b0, m_cs = 1'b1, m_mosi = 1'b0;

  always begin
    int c;
    @(negedge clk);
    c = cyc - t0 + 1;
    if (sclk && !m_sclk) begin
      rise_cnt++;
      if (rise_cnt == 1) first_rise = c;
      last_rise = c;
      hi_len = 1;
    end else if (sclk) begin
      hi_len++;
    end
    if (!sclk && m_sclk && hi_len != D) width_err++;
    if (sclk && (mosi !== m_mosi)) mosi_err++;
    if (!cs && m_cs) begin cs_fall_cnt++; cs_fall_cyc = c; end
    if (cs && !m_cs) begin cs_rise_cyc = c; ready_at_rise = tx_ready; end
    if (rx_valid) begin
      rv_cnt++;
      rv_cyc = c;
      $display("rx word 0x%02h at cycle %0d", rx_data, c);
      if (sb.size() > 0) check("rx_data", rx_data, sb.pop_front());
      else check("rx_unexpected_strobe", rx_valid, 1'b0);
    end
    m_sclk = sclk;
    m_cs   = cs;
    m_mosi = mosi;
  end

  // SPI mode-0 device model: samples MOSI on rising SCLK, shifts MISO after falling SCLK.
  logic [7:0] dev_pre[$];
  logic [7:0] dev_got[$];
  logic [7:0] d_rx = '0;
  int   d_cnt = 0;
  logic d_loaded = 1'b0, d_reload = 1'b0, d_prev = 1'b0;

  function automatic logic [7:0] next_byte();
    if (dev_pre.size() > 0) return dev_pre.pop_front();
    return 8'h00;
  endfunction

  always begin
    @(negedge clk);
    if (cs) begin
      d_loaded = 1'b0; d_reload = 1'b0; d_cnt = 0;
    end else if (!d_loaded) begin
      d_loaded = 1'b1; d_tx = next_byte();
    end else if (sclk && !d_prev) begin
      d_rx = {d_rx[6:0], mosi};
      if (d_cnt == 7) begin
        d_cnt = 0; d_reload = 1'b1; dev_got.push_back(d_rx);
      end else begin
        d_cnt++;
      end
    end else if (!sclk && d_prev) begin
      if (d_reload) begin d_tx = next_byte(); d_reload = 1'b0; end
      else d_tx = d_tx << 1;
    end
    d_prev = sclk;
  end

  task automatic clear_mon();
    @(posedge clk); #1;
    rise_cnt = 0; first_rise = 0; last_rise = 0; hi_len = 0; width_err = 0; mosi_err = 0;
    cs_fall_cnt = 0; cs_fall_cyc = 0; cs_rise_cyc = 0; rv_cnt = 0; rv_cyc = 0;
    ready_at_rise = 1'b0;
  endtask

  task automatic send(input logic [N-1:0] d, input logic l, input logic push, input logic [N-1:0] exp_rx);
    int n = 0;
    @(negedge clk);
    tx_data = d; tx_last = l; tx_valid = 1'b1;
    while (!tx_ready && n < 400) begin @(negedge clk); n++; end
    check("ready_wait", tx_ready, 1'b1);
    if (push) sb.push_back(exp_rx);
    @(posedge clk); #1;
    t0 = cyc;
    tx_valid = 1'b0;
    $display("tx word 0x%02h last=%0d accepted at cycle %0d", d, l, cyc);
  endtask

  task automatic wait_done();
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!(cs && tx_ready && sb.size() == 0) && n < 400);
    check("frame_done", {30'd0, cs, tx_ready}, 32'd3);
    check("sb_empty", sb.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nacc;
    int n;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_cs", cs, 1'b1);
    check("rst_sclk", sclk, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_tx_ready", tx_ready, 1'b1);

    // Loopback single word with full timing checks.
    miso_mode = 0;
    clear_mon();
    send(8'hA5, 1'b1, 1'b1, 8'hA5);
    wait_done();
    check("lb_rise_cnt", rise_cnt, 8);
    check("lb_first_rise", first_rise, 3);
    check("lb_last_rise", last_rise, 31);
    check("lb_high_width", width_err, 0);
    check("lb_mosi_stable", mosi_err, 0);
    check("lb_rv_cyc", rv_cyc, 33);
    check("lb_cs_fall", cs_fall_cyc, 1);
    check("lb_cs_rise", cs_rise_cyc, 35);
    check("lb_ready_at_rise", ready_at_rise, 1'b1);

    // tx_last=0 but no follow-on word: frame must close through TRAIL.
    clear_mon();
    send(8'h5B, 1'b0, 1'b1, 8'h5B);
    wait_done();
    check("nw_rise_cnt", rise_cnt, 8);
    check("nw_rv_cyc", rv_cyc, 33);
    check("nw_cs_rise", cs_rise_cyc, 35);
    check("nw_ready_at_rise", ready_at_rise, 1'b1);

    // Two chained words against the device model under one CS assertion.
    miso_mode = 3;
    dev_got.delete();
    dev_pre.push_back(8'h5A);
    dev_pre.push_back(8'h96);
    clear_mon();
    send(8'h3C, 1'b0, 1'b1, 8'h5A);
    send(8'hC3, 1'b1, 1'b1, 8'h96);
    wait_done();
    check("dev_rise_cnt", rise_cnt, 16);
    check("dev_cs_falls", cs_fall_cnt, 1);
    check("dev_cs_rise", cs_rise_cyc, 35);
    check("dev_high_width", width_err, 0);
    check("dev_got_cnt", dev_got.size(), 2);
    if (dev_got.size() == 2) begin
      check("dev_word0", dev_got[0], 8'h3C);
      check("dev_word1", dev_got[1], 8'hC3);
    end

    // Constant MISO; the old word must be held until the next strobe.
    miso_mode = 1;
    send(8'h12, 1'b1, 1'b1, 8'hFF);
    wait_done();
    check("miso1_rx", rx_data, 8'hFF);
    miso_mode = 2;
    send(8'h34, 1'b1, 1'b1, 8'h00);
    repeat (12) @(negedge clk);
    check("miso0_hold", rx_data, 8'hFF);
    wait_done();
    check("miso0_rx", rx_data, 8'h00);

    // tx_valid held high with data changing every cycle: only ready-cycle words go out.
    miso_mode = 0;
    clear_mon();
    nacc = 0;
    tx_last = 1'b1;
    tx_valid = 1'b1;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      tx_data = 8'($urandom);
      if (tx_ready) begin
        sb.push_back(tx_data);
        nacc++;
      end
    end
    @(negedge clk);
    tx_valid = 1'b0;
    wait_done();
    check("busy_edges", rise_cnt, nacc * 8);
    check("busy_words", rv_cnt, nacc);

    // Reset during the third high phase.
    clear_mon();
    send(8'hF0, 1'b1, 1'b0, 8'h00);
    n = 0;
    while (rise_cnt < 3 && n < 200) begin @(negedge clk); n++; end
    check("rst_mid_reached", rise_cnt, 3);
    #1;
    reset = 1'b1;
    #1;
    check("rst_mid_cs", cs, 1'b1);
    check("rst_mid_sclk", sclk, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_mid_ready", tx_ready, 1'b1);
    check("rst_mid_rx_data", rx_data, 8'h00);
    repeat (40) @(negedge clk);
    check("rst_mid_no_strobe", rv_cnt, 0);
    clear_mon();
    send(8'h81, 1'b1, 1'b1, 8'h81);
    wait_done();
    check("post_rst_rise_cnt", rise_cnt, 8);
    check("post_rst_rv_cnt", rv_cnt, 1);
    check("post_rst_rx", rx_data, 8'h81);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
